// File: rtl/pixel_clock_divider.sv
// Runtime-programmable integer clock divider for pixel timing.
// Produces a registered near-50% divided clock (high phase floor(D/2),
// low phase ceil(D/2)), a one-cycle strobe at each period start, and the
// phase count. Divisor and Enable are only acted on while idle or at the
// last cycle of a period, so reprogramming never truncates a period.
module pixel_clock_divider #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Enable,
  input  logic [DIV_W-1:0] Divisor,
  output logic             ClockOut,
  output logic             ClockStrobe,
  output logic [DIV_W-1:0] Count,
  output logic             Running
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_half;
  logic             r_clk_out;
  logic             r_strobe;

  logic [DIV_W-1:0] w_count_inc;
  logic [DIV_W-1:0] w_last_phase;
  logic             w_last;
  logic             w_start;

  assign w_count_inc  = r_count + 1'b1;
  assign w_last_phase = r_div - 1'b1;
  // Only meaningful while running, where r_div is never zero.
  assign w_last       = (r_count == w_last_phase);
  // A new period may begin only when enabled with a non-zero ratio.
  assign w_start      = Enable && (Divisor != '0);

  // Period sequencer: start/reload at boundaries, otherwise advance phase.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_div     <= '0;
      r_half    <= '0;
      r_clk_out <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_div     <= Divisor;
            r_half    <= Divisor >> 1;
            r_count   <= '0;
            r_clk_out <= 1'b1;
            r_strobe  <= 1'b1;
          end else begin
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_strobe  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            if (w_start) begin
              // Back-to-back period; the new ratio takes effect here only.
              r_div     <= Divisor;
              r_half    <= Divisor >> 1;
              r_count   <= '0;
              r_clk_out <= 1'b1;
              r_strobe  <= 1'b1;
            end else begin
              // Stop wins over a simultaneous ratio change: r_div is kept.
              r_state   <= ST_IDLE;
              r_count   <= '0;
              r_clk_out <= 1'b0;
              r_strobe  <= 1'b0;
            end
          end else begin
            r_count   <= w_count_inc;
            r_strobe  <= 1'b0;
            r_clk_out <= (w_count_inc < r_half);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_count   <= '0;
          r_clk_out <= 1'b0;
          r_strobe  <= 1'b0;
        end
      endcase
    end
  end

  assign ClockOut    = r_clk_out;
  assign ClockStrobe = r_strobe;
  assign Count       = r_count;
  assign Running     = (r_state == ST_RUN);

endmodule

// File: tb/tb_pixel_clock_divider.sv
// Self-checking bench for pixel_clock_divider: directed vector table,
// hand-written reset sequences and randomized traffic against a
// period-level reference model.
module tb_pixel_clock_divider;

  localparam int DIV_W = 16;

  logic             CLK;
  logic             RESET;
  logic             Enable;
  logic [DIV_W-1:0] Divisor;
  logic             ClockOut;
  logic             ClockStrobe;
  logic [DIV_W-1:0] Count;
  logic             Running;

  int checks   = 0;
  int failures = 0;

  // Reference model state: whether periods are generated, the ratio of the
  // current period and the phase within it.
  bit m_run;
  int m_div;
  int m_phase;

  pixel_clock_divider #(.DIV_W(DIV_W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Enable      (Enable),
    .Divisor     (Divisor),
    .ClockOut    (ClockOut),
    .ClockStrobe (ClockStrobe),
    .Count       (Count),
    .Running     (Running)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic             en;
    logic [DIV_W-1:0] div;
    logic             exp_out;
    logic             exp_strobe;
    logic [DIV_W-1:0] exp_count;
    logic             exp_run;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    if (!RESET) begin
      m_run   = 1'b0;
      m_phase = 0;
      m_div   = 0;
    end else if (!m_run || m_phase == m_div - 1) begin
      if (Enable && Divisor != 0) begin
        m_run   = 1'b1;
        m_div   = int'(Divisor);
        m_phase = 0;
      end else begin
        m_run   = 1'b0;
        m_phase = 0;
      end
    end else begin
      m_phase++;
    end
  endtask

  // One clock: edge, model update, then settle to the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    int e_out;
    e_out = (m_run && (m_phase == 0 || m_phase < m_div / 2)) ? 1 : 0;
    check({tag, ".ClockOut"}, int'(ClockOut), e_out);
    check({tag, ".ClockStrobe"}, int'(ClockStrobe), (m_run && m_phase == 0) ? 1 : 0);
    check({tag, ".Count"}, int'(Count), m_run ? m_phase : 0);
    check({tag, ".Running"}, int'(Running), m_run ? 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ClockOut"}, int'(ClockOut), 0);
    check({tag, ".ClockStrobe"}, int'(ClockStrobe), 0);
    check({tag, ".Count"}, int'(Count), 0);
    check({tag, ".Running"}, int'(Running), 0);
  endtask

  initial begin
    //           en  div  out strobe cnt run
    vecs[0]  = '{1'b1, 16'd4, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[1]  = '{1'b1, 16'd4, 1'b1, 1'b0, 16'd1, 1'b1};
    vecs[2]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd2, 1'b1}; // change at Count=1
    vecs[3]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd3, 1'b1};
    vecs[4]  = '{1'b1, 16'd6, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[5]  = '{1'b1, 16'd6, 1'b1, 1'b0, 16'd1, 1'b1};
    vecs[6]  = '{1'b1, 16'd6, 1'b1, 1'b0, 16'd2, 1'b1};
    vecs[7]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd3, 1'b1};
    vecs[8]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd4, 1'b1};
    vecs[9]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd5, 1'b1};
    vecs[10] = '{1'b0, 16'd6, 1'b0, 1'b0, 16'd0, 1'b0}; // stop at boundary
    vecs[11] = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[12] = '{1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0}; // no start on zero
    vecs[13] = '{1'b1, 16'd1, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[14] = '{1'b1, 16'd1, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[15] = '{1'b1, 16'd5, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[16] = '{1'b1, 16'd5, 1'b1, 1'b0, 16'd1, 1'b1};
    vecs[17] = '{1'b1, 16'd5, 1'b0, 1'b0, 16'd2, 1'b1};
    vecs[18] = '{1'b0, 16'd3, 1'b0, 1'b0, 16'd3, 1'b1}; // enable dropped mid-period
    vecs[19] = '{1'b0, 16'd3, 1'b0, 1'b0, 16'd4, 1'b1};
    vecs[20] = '{1'b0, 16'd3, 1'b0, 1'b0, 16'd0, 1'b0};

    RESET   = 1'b0;
    Enable  = 1'b1;
    Divisor = 16'd4;
    m_run   = 1'b0;
    m_div   = 0;
    m_phase = 0;

    // Outputs must stay cleared while reset is held, despite Enable=1.
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_zero("in_reset");
    end
    RESET = 1'b1;

    // Directed table.
    for (int i = 0; i < 21; i++) begin
      Enable  = vecs[i].en;
      Divisor = vecs[i].div;
      tick();
      $display("vec %0d en=%0d div=%0d -> out=%0d strobe=%0d count=%0d run=%0d",
               i, Enable, Divisor, ClockOut, ClockStrobe, Count, Running);
      check($sformatf("vec%0d.ClockOut", i), int'(ClockOut), int'(vecs[i].exp_out));
      check($sformatf("vec%0d.ClockStrobe", i), int'(ClockStrobe), int'(vecs[i].exp_strobe));
      check($sformatf("vec%0d.Count", i), int'(Count), int'(vecs[i].exp_count));
      check($sformatf("vec%0d.Running", i), int'(Running), int'(vecs[i].exp_run));
    end

    // Asynchronous reset between edges while Count=2.
    Enable  = 1'b1;
    Divisor = 16'd4;
    tick();
    tick();
    tick();
    check("async_pre.Count", int'(Count), 2);
    check("async_pre.ClockOut", int'(ClockOut), 0);
    #1 RESET = 1'b0;
    #1;
    check_zero("async_clear");
    $display("async reset at Count=2 -> out=%0d count=%0d run=%0d", ClockOut, Count, Running);
    tick();
    check_zero("async_held");
    RESET = 1'b1;
    tick();
    check("restart.ClockOut", int'(ClockOut), 1);
    check("restart.ClockStrobe", int'(ClockStrobe), 1);
    check("restart.Count", int'(Count), 0);
    check("restart.Running", int'(Running), 1);
    // Legacy 1,1,0,0 pattern over two more periods.
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("legacy%0d.ClockOut", i), int'(ClockOut), ((i % 4) < 2) ? 1 : 0);
      check($sformatf("legacy%0d.Count", i), int'(Count), i % 4);
    end
    $display("restart after reset and legacy pattern checked");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) Divisor = 16'($urandom_range(0, 9));
      Enable = ($urandom_range(0, 9) != 0);
      tick();
      check_model("rand");
    end
    $display("random phase complete");

    // Largest legal divisor: start from idle and track a stretch of phase.
    Enable = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("idle_before_max.Running", int'(Running), 0);
    Enable  = 1'b1;
    Divisor = 16'hFFFF;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_model("maxdiv");
    end
    $display("max divisor start checked, count=%0d", Count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
